// File: rtl/tugemm_sched.sv
// ============================================================================
// Module      : tugemm_sched
// Description : Round-robin two-requester scheduler feeding one tuGEMM 2x2 core.
//               Optional watchdog enabled by macro TUGEMM_SCHED_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tugemm_sched #(
  parameter int VEC_W       = 32,
  parameter int ACC_W       = 17,
  parameter int WDOG_CYCLES = 20000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [VEC_W-1:0]   req0_vec_a,
  input  logic [VEC_W-1:0]   req0_vec_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [VEC_W-1:0]   req1_vec_a,
  input  logic [VEC_W-1:0]   req1_vec_b,
  output logic               core_start,
  output logic [VEC_W-1:0]   core_vec_a,
  output logic [VEC_W-1:0]   core_vec_b,
  input  logic               core_done,
  input  logic [4*ACC_W-1:0] core_result,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [4*ACC_W-1:0] resp_result,
  output logic               resp_err,
  output logic               busy,
  output logic [15:0]        job_cycles
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               rr_q, rr_d;
  logic               id_q, id_d;
  logic [VEC_W-1:0]   vec_a_q, vec_a_d;
  logic [VEC_W-1:0]   vec_b_q, vec_b_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        job_cycles_q, job_cycles_d;
  logic               resp_valid_q, resp_valid_d;
  logic [4*ACC_W-1:0] resp_result_q, resp_result_d;
  logic               resp_err_q, resp_err_d;
  logic               grant0, grant1;

`ifdef TUGEMM_SCHED_WDOG_EN
  localparam logic [15:0] WDOG_LIM = 16'(WDOG_CYCLES);
`endif

  // A lone requester wins outright; on contention the pointer decides.
  assign grant0 = req0_valid & (~req1_valid | ~rr_q);
  assign grant1 = req1_valid & (~req0_valid |  rr_q);

  assign req0_ready  = rst & (state_q == S_IDLE) & grant0;
  assign req1_ready  = rst & (state_q == S_IDLE) & grant1;
  assign core_start  = (state_q == S_ISSUE);
  assign core_vec_a  = vec_a_q;
  assign core_vec_b  = vec_b_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = id_q;
  assign resp_result = resp_result_q;
  assign busy        = (state_q != S_IDLE);
  assign job_cycles  = job_cycles_q;
`ifdef TUGEMM_SCHED_WDOG_EN
  assign resp_err    = resp_err_q;
`else
  assign resp_err    = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    id_d          = id_q;
    vec_a_d       = vec_a_q;
    vec_b_d       = vec_b_q;
    cnt_d         = cnt_q;
    job_cycles_d  = job_cycles_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_err_d    = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (grant0 | grant1) begin
          vec_a_d = grant1 ? req1_vec_a : req0_vec_a;
          vec_b_d = grant1 ? req1_vec_b : req0_vec_b;
          id_d    = grant1;
          rr_d    = ~grant1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 16'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          resp_result_d = core_result;
          job_cycles_d  = cnt_q;
          resp_valid_d  = 1'b1;
          resp_err_d    = 1'b0;
          state_d       = S_RESP;
        end
`ifdef TUGEMM_SCHED_WDOG_EN
        else if (cnt_q >= WDOG_LIM) begin
          resp_result_d = '0;
          job_cycles_d  = WDOG_LIM;
          resp_valid_d  = 1'b1;
          resp_err_d    = 1'b1;
          state_d       = S_RESP;
        end
`endif
        else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      rr_q          <= 1'b0;
      id_q          <= 1'b0;
      vec_a_q       <= '0;
      vec_b_q       <= '0;
      cnt_q         <= '0;
      job_cycles_q  <= '0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      id_q          <= id_d;
      vec_a_q       <= vec_a_d;
      vec_b_q       <= vec_b_d;
      cnt_q         <= cnt_d;
      job_cycles_q  <= job_cycles_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_err_q    <= resp_err_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/tugemm_sched.md
Name: tugemm_sched

Overview:
- Two-requester scheduler that shares one tuGEMM 2x2 temporal/unary GEMM core.
- Arbitrates round-robin between requesters and latches the winning operand pair.
- Issues a one-cycle start pulse to the core, then waits for the core's done.
- Returns the result to the winning requester over a valid/ready response channel, tagged with the requester ID.
- Sits between the operand-producing front end and the tuGEMM core instance.

Parameters:
- VEC_W, 32, packed operand width: four signed 8-bit elements; byte0 = element 00, byte1 = 01, byte2 = 10, byte3 = 11.
- ACC_W, 17, width of each signed result element (8x8 product plus one add).
- WDOG_CYCLES, 20000, watchdog limit in cycles; used only with TUGEMM_SCHED_WDOG_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has a job.
- req0_ready  out  1  requester 0 job accepted this cycle when valid & ready.
- req0_vec_a  in  VEC_W  requester 0 matrix A.
- req0_vec_b  in  VEC_W  requester 0 matrix B.
- req1_valid  in  1  requester 1 has a job.
- req1_ready  out  1  requester 1 job accepted this cycle when valid & ready.
- req1_vec_a  in  VEC_W  requester 1 matrix A.
- req1_vec_b  in  VEC_W  requester 1 matrix B.
- core_start  out  1  one-cycle start pulse to the core.
- core_vec_a  out  VEC_W  latched A to the core.
- core_vec_b  out  VEC_W  latched B to the core.
- core_done  in  1  core finished; core_result valid this cycle.
- core_result  in  4*ACC_W  core result, element 00 in the LSBs.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  1  requester that owns the response.
- resp_result  out  4*ACC_W  latched result.
- resp_err  out  1  watchdog expired, result invalid.
- busy  out  1  scheduler state is not IDLE.
- job_cycles  out  16  cycles from core_start to core_done for the last job; saturates at 0xFFFF.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE and the RR pointer to 0 (requester 0 has priority).
  - Every output goes to 0: ready signals, core_start, core_vec_a/b, resp_*, busy, job_cycles.
  - Reset mid-job drops the job silently, gives no response, and ignores any later core_done.
- States:
  - IDLE:
    - reqX_ready = 1 only for the arbitration winner. Only one ready is ever high; ready is combinational from state, valid and the pointer.
    - If only one requester is valid, it wins. If both are valid, the requester at the RR pointer wins.
    - On handshake: latch vec_a/vec_b to core_vec_a/b, latch the ID, set the pointer to the other ID, and go to ISSUE.
  - ISSUE:
    - core_start = 1 for exactly this cycle, then go to WAIT.
    - core_vec_a/b stay stable from ISSUE until the job leaves WAIT.
  - WAIT:
    - Cycle counter counts from 1 (the first WAIT cycle).
    - On core_done: latch core_result to resp_result and the counter to job_cycles, set resp_valid=1 and resp_id, then go to RESP.
    - core_done seen during IDLE, ISSUE or RESP is ignored.
  - RESP:
    - resp_valid and resp_result are held until resp_ready=1. Then resp_valid drops the next cycle and the state returns to IDLE.
    - No new request is accepted while in RESP. The earliest new handshake is the cycle after the response handshake.
- Latency: handshake at cycle N -> core_start at N+1 -> core_done at N+1+k -> resp_valid at N+2+k.
- Throughput: one job in flight; the scheduler does not overlap jobs.
- Widths: the scheduler performs no arithmetic on results and passes them through. job_cycles counts from 1 and saturates at 0xFFFF.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1.

Optional Feature:
- Macro: TUGEMM_SCHED_WDOG_EN.
- When defined:
  - In WAIT, if the counter reaches WDOG_CYCLES without core_done, go to RESP with resp_err=1, resp_result=0 and job_cycles=WDOG_CYCLES.
  - resp_err clears on the response handshake.
- When undefined:
  - resp_err is tied to 0.
  - WAIT lasts until core_done, with no limit.

Test Plan:
- Reset, then req0 only with A=0x04030201, B=0x08070605 (elements 1,2,3,4 and 5,6,7,8); core model returns {50,43,22,19} after k=40 cycles -> core_start pulse at N+1, resp_valid at N+42, resp_id=0, elements 00/01/10/11 = 19/22/43/50, job_cycles=40.
- Both requesters valid continuously for 4 jobs -> grants in order 0,1,0,1; req ready never high for both at once.
- Hold resp_ready=0 for 10 cycles after resp_valid -> resp_valid and resp_result stay stable; no req handshake occurs; state returns to IDLE one cycle after resp_ready=1.
- Signed operands: A=0xFFFEFDFC, B=0x01020304 passed through -> core_vec_a/b equal the latched values for the whole job; result forwarded unchanged; spurious core_done injected in IDLE is ignored.
- Assert rst=0 in WAIT, with core_done arriving 2 cycles after reset release -> all outputs are 0, no response, busy=0; the next req0 is served normally.
- With TUGEMM_SCHED_WDOG_EN, WDOG_CYCLES=16, core never asserts done -> resp_valid at cycle 16 of WAIT, resp_err=1, resp_result=0; without the macro the bench stays in WAIT (busy=1) after 100 cycles.
